sdr_app_traffic_gen: RTL and testbench

//  Application-side initiator for the SDRAM controller app port. Accepts one burst command at a time,

---
 rtl/sdr_tg_pkg.sv | 6 +
 rtl/sdr_app_traffic_gen_if.sv | 31 +++
 rtl/sdr_tg_pattern.sv | 12 +
 rtl/sdr_app_traffic_gen.sv | 164 ++++++++++++++++
 tb/tb_sdr_app_traffic_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sdr_tg_pkg.sv
// sdr_tg_pkg: shared state encoding and default constants for the SDRAM app traffic generator.
package sdr_tg_pkg;
   typedef enum logic [2:0] {IDLE, REQ, WDATA, RDATA, DONE} tg_state_e;
   localparam logic [31:0] TG_INC     = 32'h1;
   localparam int          TG_TIMEOUT = 1024;
endpackage

// File: rtl/sdr_app_traffic_gen_if.sv
// sdr_app_traffic_gen_if: SDRAM controller application port; master = initiator, slave = controller.
interface sdr_app_traffic_gen_if #(
   parameter int APP_AW = 26,
   parameter int APP_DW = 32,
   parameter int APP_BW = 4,
   parameter int BL     = 9
);
   logic              app_req;
   logic [APP_AW-1:0] app_req_addr;
   logic [BL-1:0]     app_req_len;
   logic              app_req_wr_n;
   logic              app_req_ack;
   logic              app_busy_n;
   logic [APP_BW-1:0] app_wr_en_n;
   logic [APP_DW-1:0] app_wr_data;
   logic              app_wr_next_req;
   logic              app_last_wr;
   logic              app_rd_valid;
   logic              app_last_rd;
   logic [APP_DW-1:0] app_rd_data;
   modport master (
      output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_en_n, app_wr_data,
      input  app_req_ack, app_busy_n, app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd,
             app_rd_data
   );
   modport slave (
      input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_en_n, app_wr_data,
      output app_req_ack, app_busy_n, app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd,
             app_rd_data
   );
endinterface

// File: rtl/sdr_tg_pattern.sv
// sdr_tg_pattern: beat data pattern, seed + beat*INC modulo 2^DW.
module sdr_tg_pattern import sdr_tg_pkg::*; #(
   parameter int          DW  = 32,
   parameter int          BL  = 9,
   parameter logic [DW-1:0] INC = DW'(TG_INC)
) (
   input  logic [DW-1:0] seed_i,
   input  logic [BL-1:0] beat_i,
   output logic [DW-1:0] data_o
);
   assign data_o = seed_i + DW'(beat_i) * INC;
endmodule

// File: rtl/sdr_app_traffic_gen.sv
// sdr_app_traffic_gen: one-burst-at-a-time initiator that writes a seeded pattern to the
// SDRAM controller app port and checks read bursts against the same pattern.
module sdr_app_traffic_gen import sdr_tg_pkg::*; #(
   parameter int              APP_AW  = 26,
   parameter int              APP_DW  = 32,
   parameter int              APP_BW  = 4,
   parameter int              BL      = 9,
   parameter logic [APP_DW-1:0] INC   = APP_DW'(TG_INC),
   parameter int              TIMEOUT = TG_TIMEOUT
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr_n,
   input  logic [APP_AW-1:0]     cmd_addr,
   input  logic [BL-1:0]         cmd_len,
   input  logic [APP_DW-1:0]     cmd_seed,
   input  logic                  clr_stats,
   sdr_app_traffic_gen_if.master app,
   output logic                  done,
   output logic                  busy,
   output logic [15:0]           err_cnt,
   output logic                  proto_err,
   output logic                  timeout_err
);
   localparam int WW = $clog2(TIMEOUT);
   tg_state_e         state_q, state_d;
   logic              req_q, req_d, wr_n_q, wr_n_d;
   logic [APP_AW-1:0] addr_q, addr_d;
   logic [BL-1:0]     len_q, len_d, beat_q, beat_d;
   logic [APP_DW-1:0] seed_q, seed_d, wr_data_q, wpat, rpat;
   logic [APP_BW-1:0] wr_en_n_q;
   logic [WW-1:0]     wdog_q, wdog_d;
   logic [15:0]       err_q, err_d;
   logic              proto_q, proto_d, tmo_q, tmo_d, done_q, busy_q, ready_q;
   logic              last_beat, expired;
   sdr_tg_pattern #(.DW(APP_DW), .BL(BL), .INC(INC)) u_wpat (.seed_i(seed_q), .beat_i(beat_d), .data_o(wpat));
   sdr_tg_pattern #(.DW(APP_DW), .BL(BL), .INC(INC)) u_rpat (.seed_i(seed_q), .beat_i(beat_q), .data_o(rpat));
   assign last_beat = (beat_q + BL'(1)) == len_q;
   assign expired   = wdog_q == WW'(TIMEOUT - 1);
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      len_d   = len_q;
      wr_n_d  = wr_n_q;
      seed_d  = seed_q;
      beat_d  = beat_q;
      wdog_d  = wdog_q + WW'(1);
      err_d   = err_q;
      proto_d = proto_q;
      tmo_d   = tmo_q;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               wr_n_d  = cmd_wr_n;
               seed_d  = cmd_seed;
               beat_d  = '0;
               state_d = cmd_len == '0 ? DONE : REQ;
               req_d   = cmd_len != '0;
               proto_d = proto_q | (cmd_len == '0);
            end
         end
         REQ: begin
            if (app.app_req_ack) begin
               req_d   = 1'b0;
               wdog_d  = '0;
               state_d = wr_n_q ? RDATA : WDATA;
               // a write beat may already be consumed in the ack cycle
               if (!wr_n_q && app.app_wr_next_req) begin
                  beat_d  = beat_q + BL'(1);
                  proto_d = proto_q | (app.app_last_wr != last_beat);
                  state_d = last_beat ? DONE : WDATA;
               end
            end else if (expired) begin
               req_d   = 1'b0;
               tmo_d   = 1'b1;
               state_d = DONE;
            end
         end
         WDATA: begin
            if (app.app_wr_next_req) begin
               wdog_d  = '0;
               beat_d  = beat_q + BL'(1);
               proto_d = proto_q | (app.app_last_wr != last_beat);
               state_d = last_beat ? DONE : WDATA;
            end else if (expired) begin
               tmo_d   = 1'b1;
               state_d = DONE;
            end
         end
         RDATA: begin
            if (app.app_rd_valid) begin
               wdog_d  = '0;
               beat_d  = beat_q + BL'(1);
               err_d   = (app.app_rd_data != rpat && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
               proto_d = proto_q | (app.app_last_rd != last_beat);
               state_d = last_beat ? DONE : RDATA;
            end else if (expired) begin
               tmo_d   = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      proto_d = proto_d | (app.app_rd_valid && (state_q == IDLE || state_q == REQ || state_q == WDATA));
      err_d   = clr_stats ? '0 : err_d;
      proto_d = proto_d & ~clr_stats;
      tmo_d   = tmo_d & ~clr_stats;
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         wr_n_q    <= 1'b0;
         seed_q    <= '0;
         beat_q    <= '0;
         wdog_q    <= '0;
         wr_data_q <= '0;
         wr_en_n_q <= '1;
         err_q     <= '0;
         proto_q   <= 1'b0;
         tmo_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         wr_n_q    <= wr_n_d;
         seed_q    <= seed_d;
         beat_q    <= beat_d;
         wdog_q    <= wdog_d;
         wr_data_q <= state_d == WDATA ? wpat : '0;
         wr_en_n_q <= state_d == WDATA ? '0 : '1;
         err_q     <= err_d;
         proto_q   <= proto_d;
         tmo_q     <= tmo_d;
         done_q    <= state_d == DONE;
         busy_q    <= state_d != IDLE;
         ready_q   <= state_d == IDLE;
      end
   end
   assign app.app_req      = req_q;
   assign app.app_req_addr = addr_q;
   assign app.app_req_len  = len_q;
   assign app.app_req_wr_n = wr_n_q;
   assign app.app_wr_en_n  = wr_en_n_q;
   assign app.app_wr_data  = wr_data_q;
   assign cmd_ready        = ready_q;
   assign done             = done_q;
   assign busy             = busy_q;
   assign err_cnt          = err_q;
   assign proto_err        = proto_q;
   assign timeout_err      = tmo_q;
endmodule

// File: tb/tb_sdr_app_traffic_gen.sv
// tb_sdr_app_traffic_gen: directed bench acting as sequencer and SDRAM controller app port.
module tb_sdr_app_traffic_gen;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_wr_n, clr_stats, done, busy, proto_err, timeout_err;
   logic [25:0] cmd_addr;
   logic [8:0]  cmd_len;
   logic [31:0] cmd_seed;
   logic [15:0] err_cnt;
   int          n_chk = 0;
   int          n_err = 0;
   always #5 clk = ~clk;
   sdr_app_traffic_gen_if app_if ();
   sdr_app_traffic_gen dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wr_n(cmd_wr_n), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
      .clr_stats(clr_stats), .app(app_if), .done(done), .busy(busy), .err_cnt(err_cnt),
      .proto_err(proto_err), .timeout_err(timeout_err)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic wr_n, input logic [8:0] len, input logic [31:0] seed);
      int t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_wr_n  = wr_n;
      cmd_addr  = 26'h100;
      cmd_len   = len;
      cmd_seed  = seed;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask
   task automatic ack_req(input int delay);
      repeat (delay) begin
         chk("req_hold", 32'(app_if.app_req), 32'd1);
         chk("addr_hold", 32'(app_if.app_req_addr), 32'h100);
         @(negedge clk);
      end
      chk("req_before_ack", 32'(app_if.app_req), 32'd1);
      app_if.app_req_ack = 1'b1;
      @(negedge clk);
      app_if.app_req_ack = 1'b0;
      chk("req_after_ack", 32'(app_if.app_req), 32'd0);
   endtask
   task automatic wr_burst(input logic [31:0] seed, input int len);
      for (int k = 0; k < len; k++) begin
         chk("wr_en_n", 32'(app_if.app_wr_en_n), 32'h0);
         chk("wr_data", app_if.app_wr_data, seed + 32'(k));
         app_if.app_last_wr     = (k == len - 1);
         app_if.app_wr_next_req = 1'b1;
         @(negedge clk);
      end
      app_if.app_wr_next_req = 1'b0;
      app_if.app_last_wr     = 1'b0;
   endtask
   task automatic rd_burst(input logic [31:0] seed, input int len, input int bad, input int last);
      for (int k = 0; k < len; k++) begin
         app_if.app_rd_valid = 1'b1;
         app_if.app_rd_data  = (k == bad) ? 32'hDEAD : seed + 32'(k);
         app_if.app_last_rd  = (k == last);
         @(negedge clk);
      end
      app_if.app_rd_valid = 1'b0;
      app_if.app_last_rd  = 1'b0;
   endtask
   task automatic clear();
      clr_stats = 1'b1;
      @(negedge clk);
      clr_stats = 1'b0;
   endtask
   initial begin
      int cnt;
      rst = 1'b1;
      {cmd_valid, cmd_wr_n, clr_stats} = '0;
      cmd_addr = '0;
      cmd_len  = '0;
      cmd_seed = '0;
      {app_if.app_req_ack, app_if.app_wr_next_req, app_if.app_last_wr} = '0;
      {app_if.app_rd_valid, app_if.app_last_rd} = '0;
      app_if.app_busy_n  = 1'b1;
      app_if.app_rd_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_app_req", 32'(app_if.app_req), 32'd0);
      chk("rst_addr", 32'(app_if.app_req_addr), 32'd0);
      chk("rst_wr_en_n", 32'(app_if.app_wr_en_n), 32'hF);
      chk("rst_status", {done, busy, proto_err, timeout_err, err_cnt}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      // write burst, ack after three request cycles
      send(1'b0, 9'd4, 32'hA000);
      chk("wr_req", 32'(app_if.app_req), 32'd1);
      chk("wr_len", 32'(app_if.app_req_len), 32'd4);
      chk("wr_wr_n", 32'(app_if.app_req_wr_n), 32'd0);
      chk("wr_busy", {busy, cmd_ready}, 32'b10);
      chk("wr_en_n_req", 32'(app_if.app_wr_en_n), 32'hF);
      ack_req(2);
      wr_burst(32'hA000, 4);
      chk("wr_done", 32'(done), 32'd1);
      chk("wr_en_n_done", 32'(app_if.app_wr_en_n), 32'hF);
      @(negedge clk);
      chk("wr_done_pulse", {done, cmd_ready}, 32'b01);
      chk("wr_status", {proto_err, timeout_err, err_cnt}, 32'd0);
      // clean read
      send(1'b1, 9'd4, 32'hA000);
      chk("rd_wr_n", 32'(app_if.app_req_wr_n), 32'd1);
      ack_req(0);
      chk("rd_wr_en_n", 32'(app_if.app_wr_en_n), 32'hF);
      rd_burst(32'hA000, 4, -1, 3);
      chk("rd_done", 32'(done), 32'd1);
      @(negedge clk);
      chk("rd_ok_err", 32'(err_cnt), 32'd0);
      chk("rd_ok_proto", 32'(proto_err), 32'd0);
      // mismatching beat, twice, then clear
      send(1'b1, 9'd4, 32'hA000);
      ack_req(0);
      rd_burst(32'hA000, 4, 2, 3);
      @(negedge clk);
      chk("mis_err1", 32'(err_cnt), 32'd1);
      send(1'b1, 9'd4, 32'hA000);
      ack_req(0);
      rd_burst(32'hA000, 4, 2, 3);
      @(negedge clk);
      chk("mis_err2", 32'(err_cnt), 32'd2);
      chk("mis_proto", 32'(proto_err), 32'd0);
      clear();
      chk("clr_err", 32'(err_cnt), 32'd0);
      // request never acknowledged
      send(1'b1, 9'd4, 32'h0);
      cnt = 0;
      while (app_if.app_req && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      chk("tmo_req_cycles", 32'(cnt), 32'd1024);
      chk("tmo_done", 32'(done), 32'd1);
      chk("tmo_flag", 32'(timeout_err), 32'd1);
      @(negedge clk);
      chk("tmo_ready", {done, cmd_ready}, 32'b01);
      clear();
      chk("tmo_clr", 32'(timeout_err), 32'd0);
      // early last_rd
      send(1'b1, 9'd4, 32'hA000);
      ack_req(0);
      rd_burst(32'hA000, 4, -1, 1);
      @(negedge clk);
      chk("early_last_proto", 32'(proto_err), 32'd1);
      chk("early_last_err", 32'(err_cnt), 32'd0);
      clear();
      chk("proto_clr", 32'(proto_err), 32'd0);
      // zero-length command
      send(1'b1, 9'd0, 32'h0);
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_req", 32'(app_if.app_req), 32'd0);
      chk("len0_proto", 32'(proto_err), 32'd1);
      @(negedge clk);
      chk("len0_ready", 32'(cmd_ready), 32'd1);
      clear();
      // reset in the middle of a write burst
      send(1'b0, 9'd4, 32'hA000);
      ack_req(0);
      app_if.app_wr_next_req = 1'b1;
      repeat (2) @(negedge clk);
      app_if.app_wr_next_req = 1'b0;
      chk("rst_mid_beat2", app_if.app_wr_data, 32'hA002);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_req", 32'(app_if.app_req), 32'd0);
      chk("rst_mid_wr_en_n", 32'(app_if.app_wr_en_n), 32'hF);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
      // reset while the request is pending
      send(1'b0, 9'd4, 32'hA000);
      chk("rst_req_pre", 32'(app_if.app_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_req_drop", 32'(app_if.app_req), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(cmd_ready), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
